// File: rtl/num_fmt_pkg.sv
// Shared types, ASCII constants and digit-count helpers for the number formatter.
package fmt_pkg;

    typedef enum logic [1:0] {
        FMT_DEC = 2'd0,
        FMT_HEX = 2'd1,
        FMT_BIN = 2'd2
    } fmt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SIZE,
        ST_EMIT
    } fmt_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A_LC  = 8'h61;

    // 1233/4096 approximates log10(2), giving enough decimal digits for 2^width-1.
    function automatic int dec_digits(input int width);
        return ((width * 1233) >> 12) + 1;
    endfunction

    function automatic int hex_digits(input int width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/num_fmt_dd_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter; done pulses WIDTH cycles after load.
module dd_bin2bcd
    import fmt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [WIDTH-1:0]                 bin,
    output logic [4*dec_digits(WIDTH)-1:0]   bcd,
    output logic                             done
);

    localparam int DDIG = dec_digits(WIDTH);
    localparam int BW   = 4 * DDIG;
    localparam int CW   = $clog2(WIDTH + 1);

    logic [BW-1:0]    bcd_q, bcd_d, adj;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    // The load cycle already performs the first shift (adjusting all-zero BCD is a no-op).
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DDIG; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        bcd_d  = bcd_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (load) begin
            bcd_d = BW'(bin[WIDTH-1]);
            sh_d  = bin << 1;
            cnt_d = CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            {bcd_d, sh_d} = {adj, sh_q} << 1;
            cnt_d         = cnt_q - CW'(1);
            done_d        = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/num_fmt.sv
// Number-to-ASCII formatter: dec/hex/bin with minimum field width, streamed MSB-first.
module num_fmt
    import fmt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [7:0]       fw_i,
    output logic             busy_o,
    output logic [7:0]       char_o,
    output logic             char_valid_o,
    input  logic             char_ready_i,
    output logic             last_o,
    output logic             done_o
);

    localparam int DDIG = dec_digits(WIDTH);
    localparam int HDIG = hex_digits(WIDTH);
    localparam int VW   = 4 * HDIG;
    localparam int CW   = $clog2(WIDTH + 1);

    fmt_state_e             state_q, state_d;
    fmt_mode_e              mode_q, mode_d;
    logic [WIDTH-1:0]       value_q, value_d;
    logic [CW-1:0]          fw_q, fw_d;
    logic [WIDTH-1:0][3:0]  digit_q, digit_d;
    logic [CW-1:0]          total_q, total_d;
    logic [CW-1:0]          ndig_q, ndig_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [7:0]             char_q, char_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;

    logic                   dd_load;
    logic [4*DDIG-1:0]      dd_bcd;
    logic                   dd_done;
    logic [VW-1:0]          value_ext;

    logic [CW-1:0]          ndig_c, total_c;
    logic [CW-1:0]          em_total, em_ndig, em_pos, em_idx;
    logic [3:0]             em_digit;
    logic [7:0]             em_char;
    logic                   em_last;

    assign dd_load   = (state_q == ST_IDLE) && start_i;
    assign value_ext = VW'(value_q);

    dd_bin2bcd #(.WIDTH(WIDTH)) u_dd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dd_load),
        .bin   (value_i),
        .bcd   (dd_bcd),
        .done  (dd_done)
    );

    always_comb begin
        ndig_c = CW'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (digit_q[i] != 4'd0) begin
                ndig_c = CW'(i + 1);
            end
        end
        total_c = (ndig_c > fw_q) ? ndig_c : fw_q;
    end

    // Character for the next output slot: position 0 while sizing, cnt+1 while emitting.
    always_comb begin
        if (state_q == ST_SIZE) begin
            em_total = total_c;
            em_ndig  = ndig_c;
            em_pos   = '0;
        end else begin
            em_total = total_q;
            em_ndig  = ndig_q;
            em_pos   = cnt_q + CW'(1);
        end
        em_idx   = em_total - em_pos - CW'(1);
        em_digit = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) == em_idx) begin
                em_digit = digit_q[i];
            end
        end
        if (em_pos < (em_total - em_ndig)) begin
            em_char = (mode_q == FMT_DEC) ? ASCII_SPACE : ASCII_ZERO;
        end else if (em_digit < 4'd10) begin
            em_char = ASCII_ZERO + {4'd0, em_digit};
        end else begin
            em_char = ASCII_A_LC + {4'd0, em_digit} - 8'd10;
        end
        em_last = (em_pos == (em_total - CW'(1)));
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        value_d = value_q;
        fw_d    = fw_q;
        digit_d = digit_q;
        total_d = total_q;
        ndig_d  = ndig_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        char_d  = char_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    case (mode_i)
                        2'd1:    mode_d = FMT_HEX;
                        2'd2:    mode_d = FMT_BIN;
                        default: mode_d = FMT_DEC;
                    endcase
                    value_d = value_i;
                    fw_d    = (fw_i > 8'(WIDTH)) ? CW'(WIDTH) : fw_i[CW-1:0];
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (mode_q == FMT_DEC) begin
                    if (dd_done) begin
                        digit_d = '0;
                        for (int i = 0; i < DDIG; i++) begin
                            digit_d[i] = dd_bcd[4*i +: 4];
                        end
                        state_d = ST_SIZE;
                    end
                end else begin
                    digit_d = '0;
                    if (mode_q == FMT_HEX) begin
                        for (int i = 0; i < HDIG; i++) begin
                            digit_d[i] = value_ext[4*i +: 4];
                        end
                    end else begin
                        for (int i = 0; i < WIDTH; i++) begin
                            digit_d[i] = {3'b000, value_q[i]};
                        end
                    end
                    state_d = ST_SIZE;
                end
            end
            ST_SIZE: begin
                total_d = total_c;
                ndig_d  = ndig_c;
                cnt_d   = '0;
                char_d  = em_char;
                last_d  = em_last;
                valid_d = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (char_ready_i) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        char_d  = 8'h00;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        char_d = em_char;
                        last_d = em_last;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= FMT_DEC;
            value_q <= '0;
            fw_q    <= '0;
            digit_q <= '0;
            total_q <= '0;
            ndig_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            value_q <= value_d;
            fw_q    <= fw_d;
            digit_q <= digit_d;
            total_q <= total_d;
            ndig_q  <= ndig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign char_o       = char_q;
    assign char_valid_o = valid_q;
    assign last_o       = last_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_num_fmt.sv
// Scoreboard bench for num_fmt: directed strings queued on issue, checked by a negedge monitor.
module tb_num_fmt;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [15:0] value_i;
    logic [7:0]  fw_i;
    logic        busy_o;
    logic [7:0]  char_o;
    logic        char_valid_o;
    logic        char_ready_i;
    logic        last_o;
    logic        done_o;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [8:0]  exp_q[$];
    logic        use_pat = 1'b0;
    logic [15:0] ready_pat = 16'b1011_0010_1101_0011;
    int          pat_idx = 0;

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_char = 8'h00;
    logic        prev_last = 1'b0;
    logic        expect_done = 1'b0;

    num_fmt #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .value_i      (value_i),
        .fw_i         (fw_i),
        .busy_o       (busy_o),
        .char_o       (char_o),
        .char_valid_o (char_valid_o),
        .char_ready_i (char_ready_i),
        .last_o       (last_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: sim time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready: held high, or walking a fixed stall pattern for backpressure tests.
    initial begin
        char_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (use_pat) begin
                char_ready_i = ready_pat[pat_idx];
                pat_idx      = (pat_idx + 1) % 16;
            end else begin
                char_ready_i = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks hold under stall and done pulse.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall  = 1'b0;
                expect_done = 1'b0;
            end else begin
                if (expect_done || done_o) checkOutput("done_pulse", done_o, expect_done);
                expect_done = 1'b0;
                if (prev_stall) begin
                    checkOutput("hold_valid", char_valid_o, 1);
                    checkOutput("hold_char", char_o, prev_char);
                    checkOutput("hold_last", last_o, prev_last);
                end
                if (char_valid_o && char_ready_i) begin
                    checkOutput("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("char", char_o, e[7:0]);
                        checkOutput("last", last_o, e[8]);
                        expect_done = e[8];
                    end
                end
                prev_stall = char_valid_o && !char_ready_i;
                prev_char  = char_o;
                prev_last  = last_o;
            end
        end
    end

    // Queues the expected string, pulses start, scrambles inputs and checks first-char latency.
    task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] value,
                                 input logic [7:0] fw, input string exp, input int lat);
        int cyc;
        for (int i = 0; i < exp.len(); i++) begin
            exp_q.push_back({(i == exp.len() - 1), exp[i]});
        end
        start_i = 1'b1;
        mode_i  = mode;
        value_i = value;
        fw_i    = fw;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mode_i  = ~mode;
        value_i = ~value;
        fw_i    = 8'd1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!char_valid_o && cyc < 200);
        if (lat > 0) checkOutput("first_valid_latency", cyc, lat);
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (!done_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", done_o, 1);
        checkOutput("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        mode_i  = 2'd0;
        value_i = 16'h0000;
        fw_i    = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_valid", char_valid_o, 0);
        checkOutput("rst_char", char_o, 8'h00);
        checkOutput("rst_last", last_o, 0);
        checkOutput("rst_done", done_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2'd0, 16'h001a, 8'd0,   "26", 18);              waitDone();
        applyStimulus(2'd0, 16'h001a, 8'd3,   " 26", 18);             waitDone();
        applyStimulus(2'd1, 16'h001a, 8'd0,   "1a", 3);               waitDone();
        applyStimulus(2'd1, 16'h001a, 8'd3,   "01a", 3);              waitDone();
        applyStimulus(2'd2, 16'h001a, 8'd0,   "11010", 3);            waitDone();
        applyStimulus(2'd2, 16'h001a, 8'd16,  "0000000000011010", 3); waitDone();
        applyStimulus(2'd2, 16'h001a, 8'd200, "0000000000011010", 3); waitDone();
        applyStimulus(2'd0, 16'h0000, 8'd0,   "0", 18);               waitDone();
        applyStimulus(2'd0, 16'hffff, 8'd0,   "65535", 18);           waitDone();
        applyStimulus(2'd1, 16'hffff, 8'd0,   "ffff", 3);             waitDone();
        applyStimulus(2'd3, 16'h001a, 8'd0,   "26", 18);              waitDone();
        repeat (3) @(negedge clk);

        // Backpressure with an ignored start pulse mid-string.
        use_pat = 1'b1;
        applyStimulus(2'd0, 16'd12345, 8'd0, "12345", 18);
        @(posedge clk);
        #1;
        checkOutput("busy_mid_string", busy_o, 1);
        start_i = 1'b1;
        mode_i  = 2'd1;
        value_i = 16'h00ff;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        waitDone();
        use_pat = 1'b0;
        repeat (25) @(negedge clk);

        // Back-to-back: second start issued in the done cycle.
        applyStimulus(2'd0, 16'h001a, 8'd0, "26", 18);
        waitDone();
        checkOutput("busy_in_done_cycle", busy_o, 0);
        applyStimulus(2'd1, 16'hbeef, 8'd0, "beef", 3);
        waitDone();
        repeat (3) @(negedge clk);

        // Reset for one cycle during EMIT drops the string.
        applyStimulus(2'd0, 16'd12345, 8'd0, "12345", 18);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", busy_o, 0);
        checkOutput("midrst_valid", char_valid_o, 0);
        checkOutput("midrst_char", char_o, 8'h00);
        checkOutput("midrst_last", last_o, 0);
        checkOutput("midrst_done", done_o, 0);
        exp_q.delete();
        repeat (25) @(negedge clk);

        applyStimulus(2'd0, 16'd7, 8'd0, "7", 18);
        waitDone();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/num_fmt.md
# num_fmt

- Parametrised hardware number-to-ASCII formatter for the RSA ASIP.
- Converts a WIDTH-bit unsigned value into a decimal, lowercase-hex or binary character string, with an optional minimum field width.
- Streams the string out MSB-first, one byte per valid/ready handshake.
- Feeds the debug/console path so PRU results can be printed on silicon the same way the bench prints them with `%d`/`%h`/`%b`.

## Interface

- WIDTH, 16, value width in bits (legal 4..64)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  request; sampled only when busy_o=0
- mode_i  in  2  0=dec, 1=hex, 2=bin, 3=treated as dec
- value_i  in  WIDTH  unsigned value, captured on accepted start
- fw_i  in  8  minimum field width; 0 = minimal; values >WIDTH clamp to WIDTH
- busy_o  out  1  high from the cycle after start acceptance until done_o
- char_o  out  8  ASCII character
- char_valid_o  out  1  char_o valid
- char_ready_i  in  1  consumer accepts char_o when high with char_valid_o
- last_o  out  1  qualifies the final character of the string
- done_o  out  1  one-cycle pulse after the final handshake

## Operation

- States: IDLE, CONV, SIZE, EMIT.
- **IDLE:** start_i=1 captures value_i, mode_i and clamped fw_i, then moves to CONV.
- **CONV:**
  - Dec: double-dabble, exactly WIDTH cycles, into DDIG=((WIDTH*1233)>>12)+1 BCD digits.
  - Hex/bin: 1 cycle, loading nibbles/bits into the digit buffer.
- **SIZE (1 cycle):**
  - ndig = index of the most-significant nonzero digit +1; minimum 1, so value 0 gives "0".
  - total = max(ndig, fw).
- **EMIT:**
  - Outputs total characters, MSB first.
  - The first (total-ndig) characters are padding: space (0x20) for dec, '0' (0x30) for hex/bin.
  - Digits map to '0'..'9' (0x30..0x39) and 'a'..'f' (0x61..0x66).
  - last_o is high with the final character.
- **Exit:** final handshake moves to IDLE with done_o=1 in the same cycle and busy_o=0.
- **Max string length:** WIDTH characters (bin). Hex uses HDIG=ceil(WIDTH/4) digits.
- **start_i while busy:** ignored, no queuing.
- **mode_i/value_i after capture:** changes have no effect.

## Timing

- **Reset:**
  - Every output goes to 0 (char_o=0x00) and the state to IDLE.
  - Reset mid-operation drops the string; no done_o, no further valid.
- **Latency, start accept (cycle 0) to first char_valid_o:**
  - Dec: cycle WIDTH+2.
  - Hex/bin: cycle 3.
- **Handshake:**
  - char_valid_o stays high through EMIT.
  - char_o and last_o are held stable while char_valid_o=1 and char_ready_i=0.
  - The next character appears the cycle after a handshake. With char_ready_i held high, one character is emitted per cycle.
- **Throughput:** a new start_i is accepted in the cycle done_o is high (busy_o=0 then), giving back-to-back strings with one idle cycle.
- **Widths:**
  - Digit buffer is WIDTH entries × 4 bits.
  - Character counter is $clog2(WIDTH+1) bits.
  - fw clamp is compared at 8 bits before truncation.

## Structure

- **Package fmt_pkg:**
  - mode enum (FMT_DEC, FMT_HEX, FMT_BIN).
  - ASCII constants (ASCII_SPACE, ASCII_ZERO, ASCII_A_LC).
  - State enum.
  - Functions dec_digits(width) and hex_digits(width).
- **Sub-module dd_bin2bcd:**
  - Sequential double-dabble.
  - Ports clk, rst_n, load, bin, bcd, done.
  - Parametrised on WIDTH; done asserts after WIDTH cycles.
- **num_fmt owns** the FSM, digit buffer, padding logic and output register.

## Test plan

WIDTH=16, char_ready_i=1 unless stated.

- Value 0x001a:
  - dec fw=0 → "26" (last on '6', done next handshake cycle).
  - dec fw=3 → " 26".
- Value 0x001a:
  - hex fw=0 → "1a"; hex fw=3 → "01a".
  - bin fw=0 → "11010"; bin fw=16 → "0000000000011010".
  - bin fw=200 → same 16 characters (clamp).
- Dec boundaries:
  - Value 0, fw=0 → "0".
  - Value 0xffff → "65535", first valid at cycle 18 after accept.
  - Hex 0xffff → "ffff", first valid at cycle 3.
- Backpressure:
  - Pseudo-random char_ready_i on dec 12345 → exactly "12345", char_o stable under stall, single last_o.
  - start_i pulsed mid-string is ignored.
- Back-to-back: start in the done_o cycle with hex 0xbeef → "beef" follows "26" with no lost or duplicated bytes.
- Reset:
  - rst_n low for 1 cycle during EMIT → all outputs 0 next cycle, no done_o.
  - A following dec 7 → "7".
